alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
// - Shares one 32-bit ALU datapath (xor/and/add slices, all gate-delayed) between two requesters.
// - Requesters use valid/ready handshakes; grants alternate round-robin.
// - The block drives the registered operands and opcode to the ALU.
// - It waits a fixed number of settle cycles to cover gate propagation, then captures the result.
// - The captured result is returned on a single response channel tagged with the requester id.
// PARAMETERS
// - WIDTH          32  operand/result width
// - SETTLE_CYCLES  4   cycles operands are held before capture; legal 1..2**CNT_W-1
// - CNT_W          4   settle counter width
// PORTS
// - clk          in   1      single clock, rising edge
// - reset        in   1      asynchronous, active-high; clears all state immediately
// - req0_valid   in   1      requester 0 has an operation
// - req0_ready   out  1      requester 0 accepted this cycle
// - req0_a       in   WIDTH  requester 0 operand A
// - req0_b       in   WIDTH  requester 0 operand B
// - req0_op      in   3      requester 0 opcode; opaque, passed to ALU
// - req1_valid   in   1      requester 1 has an operation
// - req1_ready   out  1      requester 1 accepted this cycle
// - req1_a       in   WIDTH  requester 1 operand A
// - req1_b       in   WIDTH  requester 1 operand B
// - req1_op      in   3      requester 1 opcode
// - alu_a        out  WIDTH  registered operand A to shared ALU
// - alu_b        out  WIDTH  registered operand B to shared ALU
// - alu_op       out  3      registered opcode to shared ALU
// - alu_result   in   WIDTH  shared ALU output
// - rsp_valid    out  1      response available
// - rsp_ready    in   1      consumer takes the response
// - rsp_id       out  1      requester that owns the response
// - rsp_result   out  WIDTH  captured ALU result
// BEHAVIOUR
// - Reset values (asynchronous):
//   - state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0.
//   - alu_a/alu_b/alu_op=0, counter=0, last_grant=1 (req0 wins the first tie).
//   - reqN_ready=0 while reset is asserted.
// - FSM states: IDLE -> SETTLE -> RESP -> IDLE.
// - IDLE:
//   - reqN_ready is combinational: exactly one is high when any valid is high, none otherwise.
//   - Only one valid: that requester is granted.
//   - Both valid: the requester != last_grant is granted.
//   - On the accept edge: latch the granted a/b/op into alu_a/alu_b/alu_op, latch the id.
//   - Also on that edge: set last_grant=id, counter=SETTLE_CYCLES-1, go to SETTLE.
// - SETTLE:
//   - Both reqN_ready=0; ALU inputs are held stable.
//   - counter!=0: decrement.
//   - counter==0: on that edge capture alu_result into rsp_result, rsp_id=id, rsp_valid=1, go to RESP.
//   - The ALU inputs therefore stay stable for exactly SETTLE_CYCLES cycles before capture.
// - RESP:
//   - rsp_valid=1 and rsp_result/rsp_id are held stable until rsp_ready is seen.
//   - rsp_valid&&rsp_ready: rsp_valid=0, go to IDLE. The next accept occurs no earlier than the following cycle.
// - Latency: accept edge to rsp_valid high = SETTLE_CYCLES cycles.
// - Throughput: one op per SETTLE_CYCLES+2 cycles when rsp_ready is tied high.
// - A valid that drops before it is granted is simply not serviced; valid stays high until ready.
// - alu_a/alu_b/alu_op keep their last values in RESP and IDLE; they change only on accept.
// - Reset mid-SETTLE or mid-RESP:
//   - The in-flight op is dropped with no response; rsp_valid falls immediately.
//   - last_grant returns to 1.
// CONFIGURATION
// - Macro ALU_SHARE_ARB_PARITY_EN.
// - Defined:
//   - Adds output port rsp_parity (1 bit) = ^alu_result, registered on the capture edge together with rsp_result.
//   - rsp_parity resets to 0 and is held with rsp_result.
// - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
// - Reset, then req0 only: a=32'hFFFF0000, b=32'h0F0F0F0F, op=XOR, bench ALU model.
//   -> req0_ready pulses 1 cycle; rsp_valid exactly 4 cycles later.
//   -> rsp_id=0, rsp_result=32'hF0F00F0F.
// - Both valid every cycle, rsp_ready=1, 6 ops.
//   -> grants alternate 0,1,0,1,0,1; one accept every 6 cycles.
// - rsp_ready held 0 for 10 cycles during RESP.
//   -> rsp_valid/rsp_result/rsp_id stable; no reqN_ready pulse until rsp_ready=1.
// - Bench ALU model changes alu_result every cycle during SETTLE.
//   -> captured value equals the alu_result sampled at the 4th SETTLE edge.
// - Assert reset 2 cycles into SETTLE with req1 in flight.
//   -> rsp_valid=0 at once; after release, both valid -> req0 granted first.
// - ALU_SHARE_ARB_PARITY_EN defined, result 32'h00000007 -> rsp_parity=1;
//   result 32'h00000003 -> rsp_parity=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared, gate-delayed 32-bit ALU.
// Define ALU_SHARE_ARB_PARITY_EN to add a registered rsp_parity output (^alu_result at capture).
module alu_share_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result
`ifdef ALU_SHARE_ARB_PARITY_EN
    ,
    output logic             rsp_parity
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > (2**CNT_W) - 1) begin : g_bad_settle
        $error("alu_share_arbiter: SETTLE_CYCLES out of range for CNT_W");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;

    logic grant_id;
    logic accept;
    logic capture;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_id = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        accept   = (state_q == ST_IDLE) && (req0_valid || req1_valid) && !reset;
        capture  = (state_q == ST_SETTLE) && (cnt_q == '0);
    end

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_a_d      = grant_id ? req1_a  : req0_a;
                    alu_b_d      = grant_id ? req1_b  : req0_b;
                    alu_op_d     = grant_id ? req1_op : req0_op;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = SETTLE_LOAD;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Operands have been stable for SETTLE_CYCLES edges once the count hits zero.
                if (capture) begin
                    rsp_result_d = alu_result;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

`ifdef ALU_SHARE_ARB_PARITY_EN
    logic rsp_parity_q, rsp_parity_d;

    always_comb begin
        rsp_parity_d = capture ? ^alu_result : rsp_parity_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_parity_q <= 1'b0;
        end else begin
            rsp_parity_q <= rsp_parity_d;
        end
    end

    assign rsp_parity = rsp_parity_q;
`endif

endmodule
